// File: rtl/sifive_scope_tl_a_echo_capture_if.sv
// Bundles the snooped TileLink A-channel handshakes and the trace record stream.
// The capture block drives the record side through the master modport.
interface sifive_scope_tl_a_echo_capture_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ECHO_W   = 3,
    parameter int unsigned TS_W     = 16
);
    logic [CHANNELS-1:0]        mon_valid;
    logic [CHANNELS-1:0]        mon_ready;
    logic [CHANNELS*ECHO_W-1:0] mon_echo;
    logic                       out_valid;
    logic                       out_ready;
    logic [TS_W-1:0]            out_ts;
    logic [CHANNELS-1:0]        out_mask;
    logic [CHANNELS*ECHO_W-1:0] out_echo;

    modport master (
        input  mon_valid, mon_ready, mon_echo, out_ready,
        output out_valid, out_ts, out_mask, out_echo
    );

    modport slave (
        output mon_valid, mon_ready, mon_echo, out_ready,
        input  out_valid, out_ts, out_mask, out_echo
    );
endinterface

// File: rtl/sifive_scope_tl_a_echo_capture.sv
// Timestamps qualifying A-channel beats and queues one shared record per cycle
// in a FIFO drained by a trace sink; never back-pressures the monitored bus.
module sifive_scope_tl_a_echo_capture #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ECHO_W   = 3,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TS_W     = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         mode,
    input  logic                         clear,
    sifive_scope_tl_a_echo_capture_if.master tl,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [7:0]                   drops,
    output logic                         overflow
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned EchW = CHANNELS * ECHO_W;
    localparam int unsigned RecW = TS_W + CHANNELS + EchW;

    logic [RecW-1:0]     mem_q [DEPTH];
    logic [PtrW-1:0]     wptr_q, rptr_q;
    logic [CntW-1:0]     count_q;
    logic [7:0]          drops_q;
    logic                overflow_q;
    logic [TS_W-1:0]     ts_q;
    logic [CHANNELS-1:0] seen_q;
    logic [EchW-1:0]     last_q;

    logic [CHANNELS-1:0] fire, qual;
    logic [EchW-1:0]     rec_echo;
    logic                push_req, push_acc, pop;
    logic [RecW-1:0]     head;

    always_comb begin
        fire     = tl.mon_valid & tl.mon_ready;
        qual     = '0;
        rec_echo = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (fire[i] && (!mode || !seen_q[i] ||
                            tl.mon_echo[i*ECHO_W +: ECHO_W] != last_q[i*ECHO_W +: ECHO_W])) begin
                qual[i]                     = 1'b1;
                rec_echo[i*ECHO_W +: ECHO_W] = tl.mon_echo[i*ECHO_W +: ECHO_W];
            end
        end
    end

    // Clear overrides every other action in its cycle.
    assign pop      = (count_q != '0) & tl.out_ready & ~clear;
    assign push_req = enable & (|qual) & ~clear;
    assign push_acc = push_req & ((count_q < CntW'(DEPTH)) | pop);

    always_ff @(posedge clock) begin
        if (push_acc) begin
            mem_q[wptr_q] <= {ts_q, qual, rec_echo};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            drops_q    <= '0;
            overflow_q <= 1'b0;
            ts_q       <= '0;
            seen_q     <= '0;
            last_q     <= '0;
        end else begin
            if (enable) begin
                ts_q <= ts_q + 1'b1;
            end
            if (clear) begin
                wptr_q     <= '0;
                rptr_q     <= '0;
                count_q    <= '0;
                drops_q    <= '0;
                overflow_q <= 1'b0;
                seen_q     <= '0;
                last_q     <= '0;
            end else begin
                if (pop) begin
                    rptr_q <= rptr_q + 1'b1;
                end
                if (push_acc) begin
                    wptr_q <= wptr_q + 1'b1;
                end else if (push_req) begin
                    overflow_q <= 1'b1;
                    if (drops_q != 8'hff) begin
                        drops_q <= drops_q + 8'd1;
                    end
                end
                case ({push_acc, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
                // History tracks every fired beat, qualified or not.
                if (enable) begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (fire[i]) begin
                            seen_q[i]                  <= 1'b1;
                            last_q[i*ECHO_W +: ECHO_W] <= tl.mon_echo[i*ECHO_W +: ECHO_W];
                        end
                    end
                end
            end
        end
    end

    // Head fields read as zero whenever the FIFO is empty.
    assign tl.out_valid = (count_q != '0);
    assign head         = tl.out_valid ? mem_q[rptr_q] : '0;
    assign {tl.out_ts, tl.out_mask, tl.out_echo} = head;

    assign count    = count_q;
    assign drops    = drops_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_sifive_scope_tl_a_echo_capture.sv
// Directed bench for the echo capture block: stimulus pushes expected records into
// a queue, a negedge monitor pops and compares every record the sink accepts.
module tb_sifive_scope_tl_a_echo_capture;
    logic       clock;
    logic       reset;
    logic       enable;
    logic       mode;
    logic       clear;
    logic [4:0] count;
    logic [7:0] drops;
    logic       overflow;

    sifive_scope_tl_a_echo_capture_if #(.CHANNELS(2), .ECHO_W(3), .TS_W(4)) bus ();

    sifive_scope_tl_a_echo_capture #(
        .CHANNELS(2),
        .ECHO_W  (3),
        .DEPTH   (16),
        .TS_W    (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .mode    (mode),
        .clear   (clear),
        .tl      (bus),
        .count   (count),
        .drops   (drops),
        .overflow(overflow)
    );

    typedef struct {
        logic [3:0] ts;
        logic [1:0] mask;
        logic [5:0] echo;
    } rec_t;

    rec_t       expq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_count;
    int         m_drops;
    bit         m_ovf;
    bit   [1:0] m_seen;
    logic [5:0] m_last;
    logic [3:0] m_ts;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advances the reference model over the coming edge, then clocks the DUT.
    task automatic step();
        logic [1:0] fire;
        logic [1:0] q;
        logic [5:0] e;
        logic [2:0] ei;
        bit         pop;
        bit         acc;
        rec_t       r;
        if (reset) begin
            expq.delete();
            m_count = 0; m_drops = 0; m_ovf = 0; m_seen = 0; m_last = 0; m_ts = 0;
        end else begin
            fire = bus.mon_valid & bus.mon_ready;
            q = 0;
            e = 0;
            for (int i = 0; i < 2; i++) begin
                ei = bus.mon_echo[i*3 +: 3];
                if (fire[i] && (!mode || !m_seen[i] || ei != m_last[i*3 +: 3])) begin
                    q[i] = 1'b1;
                    e[i*3 +: 3] = ei;
                end
            end
            if (clear) begin
                expq.delete();
                m_count = 0; m_drops = 0; m_ovf = 0; m_seen = 0; m_last = 0;
            end else begin
                pop = (m_count > 0) && bus.out_ready;
                if (enable && q != 0) begin
                    acc = (m_count < 16) || pop;
                    if (acc) begin
                        r.ts = m_ts; r.mask = q; r.echo = e;
                        expq.push_back(r);
                        m_count++;
                    end else begin
                        if (m_drops < 255) m_drops++;
                        m_ovf = 1;
                    end
                end
                if (pop) m_count--;
                if (enable) begin
                    for (int i = 0; i < 2; i++) begin
                        if (fire[i]) begin
                            m_seen[i] = 1'b1;
                            m_last[i*3 +: 3] = bus.mon_echo[i*3 +: 3];
                        end
                    end
                end
            end
            if (enable) m_ts = m_ts + 4'd1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [1:0] v, input logic [1:0] r,
                        input logic [2:0] e0, input logic [2:0] e1);
        bus.mon_valid = v;
        bus.mon_ready = r;
        bus.mon_echo  = {e1, e0};
        step();
        bus.mon_valid = '0;
        bus.mon_ready = '0;
        bus.mon_echo  = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40 && count != 0; k++) step();
        bus.out_ready = 1'b0;
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_queue", 32'(expq.size()), 32'd0);
    endtask

    // Scoreboard monitor: compares each record at the point the sink accepts it.
    always @(negedge clock) begin
        rec_t r;
        if (!reset && !clear && bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_record", 32'(bus.out_ts), 32'hffff_ffff);
            end else begin
                r = expq.pop_front();
                chk("rec_ts", 32'(bus.out_ts), 32'(r.ts));
                chk("rec_mask", 32'(bus.out_mask), 32'(r.mask));
                chk("rec_echo", 32'(bus.out_echo), 32'(r.echo));
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 1'b0; clear = 1'b0;
        bus.mon_valid = '0; bus.mon_ready = '0; bus.mon_echo = '0; bus.out_ready = 1'b0;
        idle(2);
        reset = 1'b0;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ts", 32'(bus.out_ts), 32'd0);
        chk("rst_mask", 32'(bus.out_mask), 32'd0);
        chk("rst_echo", 32'(bus.out_echo), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_drops", 32'(drops), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Single beat on channel 1 at ts=7.
        enable = 1'b1;
        idle(7);
        beat(2'b10, 2'b10, 3'd0, 3'd5);
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_ts", 32'(bus.out_ts), 32'd7);
        chk("single_mask", 32'(bus.out_mask), 32'b10);
        chk("single_echo", 32'(bus.out_echo), 32'b101_000);
        chk("single_count", 32'(count), 32'd1);

        // Both channels in one cycle share a single record.
        beat(2'b11, 2'b11, 3'd2, 3'd5);
        chk("simul_count", 32'(count), 32'd2);
        drain();

        // Disabled capture: a fired beat produces nothing.
        enable = 1'b0;
        beat(2'b01, 2'b01, 3'd4, 3'd0);
        chk("disabled_count", 32'(count), 32'd0);
        enable = 1'b1;

        // Change-only mode: valid without ready, then 4,4,6,6.
        mode = 1'b1;
        beat(2'b01, 2'b00, 3'd7, 3'd0);
        chk("noready_count", 32'(count), 32'd0);
        beat(2'b01, 2'b01, 3'd4, 3'd0);
        beat(2'b01, 2'b01, 3'd4, 3'd0);
        beat(2'b01, 2'b01, 3'd6, 3'd0);
        beat(2'b01, 2'b01, 3'd6, 3'd0);
        chk("change_count", 32'(count), 32'd2);
        drain();

        // Overflow, then full FIFO with simultaneous push and pop.
        mode = 1'b0;
        for (int i = 0; i < 20; i++) beat(2'b01, 2'b01, 3'(i % 8), 3'd0);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_drops", 32'(drops), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        bus.out_ready = 1'b1;
        beat(2'b01, 2'b01, 3'd3, 3'd0);
        bus.out_ready = 1'b0;
        chk("fullpp_count", 32'(count), 32'd16);
        chk("fullpp_drops", 32'(drops), 32'd4);
        for (int i = 0; i < 300; i++) beat(2'b01, 2'b01, 3'(i % 8), 3'd0);
        chk("sat_drops", 32'(drops), 32'd255);
        chk("sat_count", 32'(count), 32'd16);

        // Clear with a same-cycle fire; history restarts.
        clear = 1'b1;
        beat(2'b01, 2'b01, 3'd5, 3'd0);
        clear = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_drops", 32'(drops), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        mode = 1'b1;
        beat(2'b01, 2'b01, 3'd3, 3'd0);
        chk("clr_first_count", 32'(count), 32'd1);
        beat(2'b01, 2'b01, 3'd3, 3'd0);
        chk("clr_repeat_count", 32'(count), 32'd1);
        drain();

        // Reset with entries queued, then timestamp wrap after 17 enabled cycles.
        mode = 1'b0;
        for (int i = 0; i < 5; i++) beat(2'b10, 2'b10, 3'd0, 3'(i));
        chk("pre_rst_count", 32'(count), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_ts", 32'(bus.out_ts), 32'd0);
        chk("midrst_mask", 32'(bus.out_mask), 32'd0);
        chk("midrst_echo", 32'(bus.out_echo), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_drops", 32'(drops), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        mode = 1'b1;
        idle(17);
        beat(2'b01, 2'b01, 3'd0, 3'd0);
        chk("wrap_ts", 32'(bus.out_ts), 32'd1);
        chk("wrap_mask", 32'(bus.out_mask), 32'b01);
        chk("wrap_echo", 32'(bus.out_echo), 32'd0);
        chk("wrap_count", 32'(count), 32'd1);
        drain();

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
